crc_mem_arbiter: RTL and testbench
==================================

// Module: crc_mem_arbiter
// PURPOSE
//  Shares the single-port 1024x8 CRC image memory between a host port (read/write) and the
//  CRC fetch FSM (read-only). Round-robin req/gnt arbitration, one access per grant, read data
//  routed back to the issuing requester. Sits between the host bus, the CRC FSM and the memory.
// PARAMETERS
//  ADDR_W   10   memory address width (1024 words)
//  DATA_W   8    memory data width
//  RD_LAT   2    memory read latency in cycles, grant cycle to rdata valid (>=1)
// PORTS
//  clk50m       in   1       system clock, all logic on rising edge
//  rst          in   1       asynchronous reset, active-high
//  host_req     in   1       host access request, held with addr/we/wdata until host_gnt
//  host_we      in   1       1=write, 0=read
//  host_addr    in   ADDR_W  host address
//  host_wdata   in   DATA_W  host write data
//  host_gnt     out  1       one-cycle grant pulse; access issued this cycle
//  host_rvalid  out  1       one-cycle pulse, host_rdata valid
//  host_rdata   out  DATA_W  host read data
//  crc_req      in   1       CRC FSM read request, held with crc_addr until crc_gnt
//  crc_addr     in   ADDR_W  CRC read address
//  crc_gnt      out  1       one-cycle grant pulse
//  crc_rvalid   out  1       one-cycle pulse, crc_rdata valid
//  crc_rdata    out  DATA_W  CRC read data
//  crc_busy     in   1       CRC run in progress (used only with CRC_LOCK_EN)
//  mem_addr     out  ADDR_W  memory address
//  mem_we       out  1       memory write enable
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read data, RD_LAT cycles after the grant cycle
//  conflict_cnt out  16      cycles in which both requests competed for a decision
// BEHAVIOUR
//  - Reset: state ARB_IDLE, all gnt/rvalid/mem_we 0, mem_addr/mem_wdata/rdata 0, last_winner=HOST,
//    conflict_cnt 0, read tag pipe cleared (in-flight reads dropped, no rvalid after reset).
//  - FSM: ARB_IDLE -> ARB_GNT_HOST | ARB_GNT_CRC on eligible request; ARB_GNT_* -> ARB_IDLE always.
//    Max one access per 2 cycles; the idle cycle lets the winner drop req (no double grant).
//  - Decision in ARB_IDLE from inputs; in following ARB_GNT_* cycle gnt=1 and mem_addr/mem_we/
//    mem_wdata driven from registered copies of winner's request. crc access: mem_we=0 always.
//  - Round robin: only one eligible -> it wins; both eligible -> the one not in last_winner wins;
//    last_winner updated on every grant. First tie after reset goes to CRC.
//  - Read return: RD_LAT-deep tag pipe of {valid, src}; on exit pulse matching *_rvalid and
//    register mem_rdata into matching *_rdata (other rdata holds). Writes create no tag.
//  - conflict_cnt: +1 per ARB_IDLE cycle with both requests eligible; saturates at 16'hFFFF.
//  - req dropped before gnt: request withdrawn, no access. Requests in ARB_GNT_* cycles ignored.
//  - Mid-operation reset: immediate, as above; requesters re-request after release.
// CONFIGURATION
//  CRC_LOCK_EN defined: while crc_busy=1 a host write is not eligible (held pending, no gnt);
//   host reads stay eligible. Guarantees the image is stable during a CRC pass.
//   Lock evaluated in ARB_IDLE only; a write granted before crc_busy rises completes.
//  CRC_LOCK_EN undefined: crc_busy ignored, host writes arbitrate like reads.
// STRUCTURE
//  crc_pkg: ADDR_W/DATA_W defaults, typedef enum {ARB_IDLE, ARB_GNT_HOST, ARB_GNT_CRC} arb_state_t,
//   typedef enum logic {SRC_HOST, SRC_CRC} src_t, struct rd_tag_t {valid, src}.
//  Sub-module crc_rd_tag_pipe: RD_LAT-stage shift register of rd_tag_t, async active-high reset.
// TESTING
//  1 host write 0x3A@0x005, then host read 0x005 -> gnt 1 cycle after req, host_rvalid 2 cycles
//    after read gnt, host_rdata=0x3A, crc_rvalid never asserts.
//  2 both req held from reset -> grants alternate CRC,HOST,CRC,... one per 2 cycles;
//    conflict_cnt increments once per decision.
//  3 CRC reads 0x000..0x3FF alone -> 1024 crc_gnt, 1024 crc_rvalid, in address order, no gaps >2.
//  4 CRC_LOCK_EN, crc_busy=1, host write req -> no host_gnt until crc_busy=0, then grant within
//    2 cycles; without macro -> granted in round-robin turn.
//  5 rst pulse 1 cycle after crc read gnt -> no crc_rvalid, all outputs 0, conflict_cnt=0.
//  6 force 65540 conflict cycles -> conflict_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and default sizes for the CRC image memory arbiter and its read-tag pipe.
package crc_pkg;
   localparam int CRC_ADDR_W = 10;
   localparam int CRC_DATA_W = 8;
   localparam int CRC_RD_LAT = 2;

   typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_HOST, ARB_GNT_CRC} arb_state_t;
   typedef enum logic {SRC_HOST, SRC_CRC} src_t;

   typedef struct packed {
      logic valid;
      src_t src;
   } rd_tag_t;
endpackage

// File: rtl/crc_rd_tag_pipe.sv
// Delays a read tag by RD_LAT cycles so it lines up with the memory read data.
// No backpressure: one tag enters and one leaves every cycle.
module crc_rd_tag_pipe
   import crc_pkg::*;
#(
   parameter int RD_LAT = CRC_RD_LAT
) (
   input  logic    clk50m,
   input  logic    rst,
   input  rd_tag_t tag_i,
   output rd_tag_t tag_o
);
   rd_tag_t stage_q [RD_LAT];

   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tag_o = stage_q[RD_LAT-1];
endmodule

// File: rtl/crc_mem_arbiter.sv
// Round-robin share of the CRC image memory between host (rd/wr) and CRC fetch (rd); grant one cycle
// after request, read data RD_LAT cycles after grant; requesters hold req until gnt. Option: CRC_LOCK_EN.
module crc_mem_arbiter
   import crc_pkg::*;
#(
   parameter int ADDR_W = CRC_ADDR_W,
   parameter int DATA_W = CRC_DATA_W,
   parameter int RD_LAT = CRC_RD_LAT
) (
   input  logic              clk50m,
   input  logic              rst,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   input  logic              crc_req,
   input  logic [ADDR_W-1:0] crc_addr,
   output logic              crc_gnt,
   output logic              crc_rvalid,
   output logic [DATA_W-1:0] crc_rdata,
   input  logic              crc_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       conflict_cnt
);
   arb_state_t        state_q, state_d;
   src_t              last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [15:0]       conflict_q, conflict_d;
   logic [DATA_W-1:0] host_rdata_q, crc_rdata_q;
   logic              host_elig, crc_elig;
   logic              host_ret, crc_ret;
   rd_tag_t           tag_in, tag_out;

`ifdef CRC_LOCK_EN
   // Host writes wait while a CRC pass runs so the image stays stable; reads are harmless.
   assign host_elig = host_req && !(host_we && crc_busy);
`else
   logic unused_crc_busy;
   assign unused_crc_busy = crc_busy;
   assign host_elig = host_req;
`endif
   assign crc_elig = crc_req;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      conflict_d = conflict_q;
      case (state_q)
         ARB_IDLE: begin
            if (host_elig && crc_elig && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
            if (host_elig && (!crc_elig || last_q == SRC_CRC)) begin
               state_d = ARB_GNT_HOST;
               last_d  = SRC_HOST;
               addr_d  = host_addr;
               wdata_d = host_wdata;
               we_d    = host_we;
            end else if (crc_elig) begin
               state_d = ARB_GNT_CRC;
               last_d  = SRC_CRC;
               addr_d  = crc_addr;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         last_q     <= SRC_HOST;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         conflict_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         conflict_q <= conflict_d;
      end
   end

   assign host_gnt     = (state_q == ARB_GNT_HOST);
   assign crc_gnt      = (state_q == ARB_GNT_CRC);
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign mem_we       = we_q;
   assign conflict_cnt = conflict_q;

   always_comb begin
      tag_in.valid = crc_gnt || (host_gnt && !we_q);
      tag_in.src   = crc_gnt ? SRC_CRC : SRC_HOST;
   end

   crc_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .clk50m (clk50m),
      .rst    (rst),
      .tag_i  (tag_in),
      .tag_o  (tag_out)
   );

   assign host_ret = tag_out.valid && (tag_out.src == SRC_HOST);
   assign crc_ret  = tag_out.valid && (tag_out.src == SRC_CRC);

   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         host_rdata_q <= '0;
         crc_rdata_q  <= '0;
      end else begin
         if (host_ret) host_rdata_q <= mem_rdata;
         if (crc_ret)  crc_rdata_q  <= mem_rdata;
      end
   end

   // Returning data is passed straight through in its valid cycle, then held.
   assign host_rvalid = host_ret;
   assign crc_rvalid  = crc_ret;
   assign host_rdata  = host_ret ? mem_rdata : host_rdata_q;
   assign crc_rdata   = crc_ret  ? mem_rdata : crc_rdata_q;
endmodule

// File: tb/tb_crc_mem_arbiter.sv
// Directed bench for crc_mem_arbiter with a two-stage (RD_LAT=2) memory model.
module tb_crc_mem_arbiter;
   logic        clk50m = 1'b0;
   logic        rst;
   logic        host_req, host_we, host_gnt, host_rvalid;
   logic [9:0]  host_addr;
   logic [7:0]  host_wdata, host_rdata;
   logic        crc_req, crc_gnt, crc_rvalid, crc_busy;
   logic [9:0]  crc_addr;
   logic [7:0]  crc_rdata;
   logic [9:0]  mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata, mem_rdata, rd_p1;
   logic [15:0] conflict_cnt;
   logic [54:0] outs;

   int n_cmp = 0;
   int n_bad = 0;

   bit [7:0] mem_arr [1024];
   bit       mem_wr  [1024];

   always #5 clk50m = ~clk50m;

   crc_mem_arbiter u_dut (
      .clk50m(clk50m), .rst(rst),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .crc_req(crc_req), .crc_addr(crc_addr), .crc_gnt(crc_gnt), .crc_rvalid(crc_rvalid),
      .crc_rdata(crc_rdata), .crc_busy(crc_busy),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .conflict_cnt(conflict_cnt)
   );

   assign outs = {host_gnt, host_rvalid, host_rdata, crc_gnt, crc_rvalid, crc_rdata,
                  mem_addr, mem_we, mem_wdata, conflict_cnt};

   // Unwritten locations read back a fixed address-dependent pattern.
   function automatic logic [7:0] pat(input int a);
      logic [9:0] av;
      av = a[9:0];
      return av[7:0] ^ {av[9:8], 6'h15};
   endfunction

   always @(posedge clk50m) begin
      if (mem_we) begin
         mem_arr[mem_addr] <= mem_wdata;
         mem_wr[mem_addr]  <= 1'b1;
      end
      rd_p1     <= mem_wr[mem_addr] ? mem_arr[mem_addr] : pat(int'(mem_addr));
      mem_rdata <= rd_p1;
   end

   task automatic step();
      @(negedge clk50m);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      n_cmp++;
      if (outs !== 55'd0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", outs); end
      rst = 1'b0;
      step(); step();
      n_cmp++;
      if (outs !== 55'd0) begin n_bad++; $display("FAIL idle_outs: got %h want 0", outs); end
   endtask

   task automatic test_crc_sweep();
      int gnts, rx, bad, last_rv, maxgap, bad_idx;
      logic [7:0] bad_got;
      bit host_seen;
      gnts = 0; rx = 0; bad = 0; last_rv = -1; maxgap = 0; bad_idx = -1; bad_got = '0; host_seen = 0;
      crc_addr = '0;
      crc_req  = 1'b1;
      for (int cyc = 0; cyc < 2200 && rx < 1024; cyc++) begin
         step();
         if (host_gnt || host_rvalid) host_seen = 1;
         if (crc_rvalid) begin
            if (crc_rdata !== pat(rx)) begin
               bad++;
               if (bad_idx < 0) begin bad_idx = rx; bad_got = crc_rdata; end
            end
            if (last_rv >= 0 && cyc - last_rv > maxgap) maxgap = cyc - last_rv;
            last_rv = cyc;
            rx++;
         end
         if (crc_gnt) begin
            if (mem_addr !== 10'(gnts) || mem_we !== 1'b0) bad++;
            gnts++;
            if (gnts < 1024) crc_addr = 10'(gnts);
            else crc_req = 1'b0;
         end
      end
      crc_req = 1'b0;
      n_cmp++;
      if (gnts != 1024) begin n_bad++; $display("FAIL sweep_gnts: got %0d want 1024", gnts); end
      n_cmp++;
      if (rx != 1024) begin n_bad++; $display("FAIL sweep_rvalids: got %0d want 1024", rx); end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL sweep_data: %0d bad, first idx %0d got %h want %h", bad, bad_idx, bad_got, pat(bad_idx));
      end
      n_cmp++;
      if (maxgap > 2 || maxgap == 0) begin n_bad++; $display("FAIL sweep_gap: got %0d want 2", maxgap); end
      n_cmp++;
      if (host_seen) begin n_bad++; $display("FAIL sweep_host_quiet: got host activity want none"); end
   endtask

   task automatic test_host_wr_rd();
      int lat;
      bit crc_seen;
      step();
      host_req = 1'b1; host_we = 1'b1; host_addr = 10'h005; host_wdata = 8'h3A;
      step();
      n_cmp++;
      if (host_gnt !== 1'b1) begin n_bad++; $display("FAIL wr_gnt: got %b want 1", host_gnt); end
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'h005, 8'h3A}) begin
         n_bad++; $display("FAIL wr_bus: got we=%b a=%h d=%h want we=1 a=005 d=3a", mem_we, mem_addr, mem_wdata);
      end
      host_req = 1'b0; host_we = 1'b0; host_wdata = '0;
      step();
      host_req = 1'b1;
      step();
      n_cmp++;
      if ({host_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h005}) begin
         n_bad++; $display("FAIL rd_gnt: got gnt=%b we=%b a=%h want 1 0 005", host_gnt, mem_we, mem_addr);
      end
      host_req = 1'b0;
      lat = 0; crc_seen = 0;
      while (lat < 8) begin
         step();
         lat++;
         if (crc_rvalid) crc_seen = 1;
         if (host_rvalid) break;
      end
      n_cmp++;
      if (lat != 2) begin n_bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
      n_cmp++;
      if (host_rdata !== 8'h3A) begin n_bad++; $display("FAIL rd_data: got %h want 3a", host_rdata); end
      step();
      if (crc_rvalid) crc_seen = 1;
      n_cmp++;
      if ({host_rvalid, host_rdata} !== {1'b0, 8'h3A}) begin
         n_bad++; $display("FAIL rd_hold: got v=%b d=%h want v=0 d=3a", host_rvalid, host_rdata);
      end
      n_cmp++;
      if (crc_rdata !== pat(1023)) begin n_bad++; $display("FAIL crc_hold: got %h want %h", crc_rdata, pat(1023)); end
      n_cmp++;
      if (crc_seen) begin n_bad++; $display("FAIL rd_crc_quiet: got crc_rvalid want none"); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      rst = 1'b1;
      host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010;
      crc_req  = 1'b1; crc_addr = 10'h020;
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         exp_g = (i % 4 == 0) ? 2'b01 : (i % 4 == 2) ? 2'b10 : 2'b00;
         n_cmp++;
         if ({host_gnt, crc_gnt} !== exp_g) begin
            n_bad++; $display("FAIL rr_gnt[%0d]: got host,crc=%b want %b", i, {host_gnt, crc_gnt}, exp_g);
         end
         n_cmp++;
         if (conflict_cnt !== 16'(i / 2 + 1)) begin
            n_bad++; $display("FAIL rr_conflict[%0d]: got %0d want %0d", i, conflict_cnt, i / 2 + 1);
         end
      end
      host_req = 1'b0; crc_req = 1'b0;
      step(); step(); step();
   endtask

   task automatic test_lock();
      int lat, g;
      crc_busy = 1'b1;
      step();
      host_req = 1'b1; host_we = 1'b0; host_addr = 10'h100;
      step();
      n_cmp++;
      if (host_gnt !== 1'b1) begin n_bad++; $display("FAIL busy_rd_gnt: got %b want 1", host_gnt); end
      host_req = 1'b0;
      step();
      host_req = 1'b1; host_we = 1'b1; host_addr = 10'h101; host_wdata = 8'hC3;
`ifdef CRC_LOCK_EN
      g = 0;
      repeat (8) begin step(); if (host_gnt) g++; end
      n_cmp++;
      if (g != 0) begin n_bad++; $display("FAIL lock_hold: got %0d grants want 0", g); end
      crc_busy = 1'b0;
      lat = 0;
      while (lat < 2) begin step(); lat++; if (host_gnt) break; end
      n_cmp++;
      if (host_gnt !== 1'b1 || mem_we !== 1'b1) begin
         n_bad++; $display("FAIL lock_release: got gnt=%b we=%b want 1 1", host_gnt, mem_we);
      end
`else
      g = 0; lat = 0;
      step();
      n_cmp++;
      if (host_gnt !== 1'b1 || mem_we !== 1'b1) begin
         n_bad++; $display("FAIL nolock_wr_gnt: got gnt=%b we=%b want 1 1", host_gnt, mem_we);
      end
`endif
      host_req = 1'b0; host_we = 1'b0; crc_busy = 1'b0;
      step();
   endtask

   task automatic test_mid_reset();
      int w;
      bit rv;
      step();
      crc_req = 1'b1; crc_addr = 10'h007;
      w = 0;
      do begin step(); w++; end while (!crc_gnt && w < 4);
      n_cmp++;
      if (crc_gnt !== 1'b1) begin n_bad++; $display("FAIL mrst_gnt: got %b want 1", crc_gnt); end
      crc_req = 1'b0;
      step();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (outs !== 55'd0) begin n_bad++; $display("FAIL mrst_outs: got %h want 0", outs); end
      step();
      rst = 1'b0;
      rv = 0;
      repeat (6) begin step(); if (crc_rvalid || host_rvalid) rv = 1; end
      n_cmp++;
      if (rv) begin n_bad++; $display("FAIL mrst_rvalid: got rvalid after reset want none"); end
      n_cmp++;
      if (outs !== 55'd0) begin n_bad++; $display("FAIL mrst_after: got %h want 0", outs); end
   endtask

   task automatic test_saturate();
      step();
      force u_dut.conflict_q = 16'hFFFC;
      step();
      release u_dut.conflict_q;
      step();
      n_cmp++;
      if (conflict_cnt !== 16'hFFFC) begin n_bad++; $display("FAIL sat_preset: got %h want fffc", conflict_cnt); end
      host_req = 1'b1; host_we = 1'b0; host_addr = 10'h033; crc_req = 1'b1; crc_addr = 10'h044;
      step(); step(); step();
      n_cmp++;
      if (conflict_cnt !== 16'hFFFE) begin n_bad++; $display("FAIL sat_step: got %h want fffe", conflict_cnt); end
      repeat (12) step();
      n_cmp++;
      if (conflict_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt); end
      host_req = 1'b0; crc_req = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      crc_req = 1'b0; crc_addr = '0; crc_busy = 1'b0;
      test_reset();
      test_crc_sweep();
      test_host_wr_rd();
      test_round_robin();
      test_lock();
      test_mid_reset();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
